rpc_multi_channel: RTL and testbench
====================================

# rpc_multi_channel

Multi-channel RPC processing unit between the per-flow CPU interface queues and the network packet path of one NIC. It serialises RPCs from N_CH independent CPU channels into `NetworkPacketInternal` frames through per-channel FIFOs and a round-robin arbiter with network backpressure. It deserialises received frames back to the channel selected by connection id. It also parses connection-setup frames and drives the existing `connection_manager`.

## Interface
Parameters:
- NIC_ID, 0, NIC index used in simulation messages
- N_CH, 4, number of CPU channels; power of two, 2..16
- TX_FIFO_DEPTH, 8, entries per channel TX FIFO; power of two, ≥2
- MAX_ARGL, 64, largest legal `rpc_data.hdr.argl` in bytes

Ports (the clock is `clk`; `reset` is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- initialize  in  1  forwarded to `connection_manager`
- conn_setup_en_in  in  1  setup frame valid
- conn_setup_frame_in  in  ConnSetupFrame  setup command and data
- conn_setup_status_out  out  ConnSetupStatus  from `connection_manager`
- rpc_valid_in  in  N_CH  per-channel RPC valid
- rpc_in  in  RpcIf[N_CH]  per-channel RPC
- rpc_ready_out  out  N_CH  per-channel accept; high when that channel's FIFO is not full
- rpc_valid_out  out  N_CH  per-channel received RPC valid; one-hot or zero
- rpc_out  out  RpcIf[N_CH]  per-channel received RPC
- network_tx_out  out  NetworkPacketInternal  outgoing frame
- network_tx_valid_out  out  1  frame valid
- network_tx_ready_in  in  1  network accepts frame
- network_rx_in  in  NetworkPacketInternal  incoming frame
- network_rx_valid_in  in  1  incoming valid; no backpressure
- drop_cnt_out  out  16  saturating count of dropped oversize RPCs
- initialized  out  1  from `connection_manager`
- error  out  1  sticky error flag

## Operation
- **TX accept:**
  - Channel c accepts an RPC when `rpc_valid_in[c] & rpc_ready_out[c]`.
  - If argl ≤ MAX_ARGL, the RPC is pushed into FIFO c.
  - Otherwise it is consumed but not pushed, `drop_cnt_out` increments (saturating at 0xFFFF), and the sticky drop error is set.
- **Arbitration:**
  - Round-robin over non-empty FIFOs, starting at `last_grant+1` mod N_CH.
  - `last_grant` resets to N_CH-1, so channel 0 has first priority.
  - At most one pop per cycle. A pop occurs only when the output register is empty or is being consumed (`!network_tx_valid_out | network_tx_ready_in`).
- **Serialise** (on pop, into the output register):
  - `payload_size = ($bits(RpcHeader)>>3) + argl`, width of `hdr.payload_size`, no overflow possible by the MAX_ARGL bound.
  - `payload[$bits(RpcPckt)-1:0] = rpc_data`; the remaining payload bits are zero.
  - `conn_id = flow_id`.
- **Output hold:** while `network_tx_valid_out & !network_tx_ready_in`, the output register and valid are held unchanged.
- **RX:**
  - On `network_rx_valid_in`, channel `ch = conn_id[$clog2(N_CH)-1:0]`.
  - Next cycle `rpc_valid_out[ch]=1` with `rpc_out[ch].rpc_data = payload[$bits(RpcPckt)-1:0]` and `flow_id = conn_id`.
  - All other channels have valid 0 and data zero.
- **Setup parser:**
  - Commands setUpConnId, setUpOpen, setUpDestIPv4, setUpDestPort and setUpClientFlowId each latch their field and set bits 0..4 of the 5-bit setup vector.
  - setUpEnable with open=1 requires all 5 bits; with open=0 it requires bit 0.
  - On success: one-cycle `c_ctl.enable` pulse, and all 5 bits are cleared.
  - On failure, or on an unknown command: sticky parse error set, and all 5 bits are cleared.
- `error = parse_err | drop_err | ct_error`. The sticky error bits clear only on reset.

## Timing
- Reset values:
  - `network_tx_valid_out=0` and `network_tx_out` zero.
  - `rpc_valid_out=0` and `rpc_out` zero.
  - All FIFOs empty; `rpc_ready_out` all 1 from the first cycle after reset.
  - `drop_cnt_out=0`; `error=0`; setup vector 0; `c_ctl.enable=0`.
- Reset mid-operation discards all FIFO contents and the held output frame.
- TX latency, with empty FIFOs and `network_tx_ready_in=1`:
  - An RPC accepted at cycle t is pushed at the end of t, popped at t+1, and has `network_tx_valid_out=1` at t+2.
- Sustained throughput is one frame per cycle across channels.
- `rpc_ready_out[c]` comes from a registered occupancy count, so a push and a pop in the same cycle keep occupancy constant.
- With a full FIFO, ready is 0. With exactly one free entry, ready is 1.
- RX latency is 1 cycle. Back-to-back RX frames produce back-to-back outputs.
- `c_ctl.enable` pulses in the cycle after the setUpEnable frame.

## Structure
- The shared NIC package holds:
  - types `RpcIf`, `RpcPckt`, `RpcHeader`, `NetworkPacketInternal`, `ConnSetupFrame`, `ConnSetupStatus`, `ConnectionControlIf`;
  - setup command enum;
  - constant `LCONN_TBL_SIZE`;
  - new constant `RPC_MAX_ARGL_DEFAULT`.
- Sub-module `rpc_tx_fifo` (parametrised by depth; RpcIf entries; push/pop, registered count, full/empty) is instantiated N_CH times.
- `connection_manager` is instantiated unchanged with `LCACHE_SIZE=LCONN_TBL_SIZE`.

## Test plan
- **Single RPC:**
  - Stimulus: ch2, flow_id=5, argl=16, ready held 1.
  - Response: frame at t+2 with conn_id=5, payload_size=header bytes+16, one valid cycle.
- **Round-robin:**
  - Stimulus: N_CH=4, all channels hold 3 RPCs each.
  - Response: output channel order 0,1,2,3,0,1,2,3,0,1,2,3.
- **Backpressure:**
  - Stimulus: `network_tx_ready_in=0` for 10 cycles, ch0 valid every cycle.
  - Response: frame held stable; `rpc_ready_out[0]` drops after 8 accepts plus 1 held frame (9 RPCs accepted); all 9 frames emitted in order after ready returns, none lost.
- **Oversize:**
  - Stimulus: argl=MAX_ARGL+1 on ch1.
  - Response: no frame; drop_cnt=1; error=1 next cycle and stays until reset.
- **RX demux:**
  - Stimulus: conn_id=6 with N_CH=4.
  - Response: `rpc_valid_out=4'b0100` one cycle later, flow_id=6.
- **Setup:**
  - Stimulus: open sequence missing DestPort, then a reset, then a full open sequence.
  - Response: first attempt sets error with no enable; after reset, the full sequence gives a single enable pulse, error=0, and the vector is cleared.

Source files
------------

// File: rtl/rpc_multi_channel_pkg.sv
// rpc_multi_channel_pkg: shared NIC types, setup command enum, table size and RPC argl bound
package rpc_multi_channel_pkg;
  localparam int LCONN_TBL_SIZE = 16;
  localparam int RPC_MAX_ARGL_DEFAULT = 64;
  localparam int NET_PAYLOAD_W = 192;
  typedef struct packed {
    logic [31:0] rpc_id;
    logic [15:0] fn_id;
    logic [15:0] argl;
  } RpcHeader;
  typedef struct packed {
    RpcHeader hdr;
    logic [63:0] args;
  } RpcPckt;
  typedef struct packed {
    logic [15:0] flow_id;
    RpcPckt rpc_data;
  } RpcIf;
  typedef struct packed {
    logic [15:0] payload_size;
  } NetworkHeader;
  typedef struct packed {
    logic [15:0] conn_id;
    NetworkHeader hdr;
    logic [NET_PAYLOAD_W-1:0] payload;
  } NetworkPacketInternal;
  typedef enum logic [2:0] {
    setUpConnId, setUpOpen, setUpDestIPv4, setUpDestPort, setUpClientFlowId, setUpEnable
  } SetupCmd;
  typedef struct packed {
    SetupCmd cmd;
    logic [31:0] data;
  } ConnSetupFrame;
  typedef struct packed {
    logic enable;
    logic open;
    logic [15:0] conn_id;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic [15:0] client_flow_id;
  } ConnectionControlIf;
  typedef struct packed {
    logic [LCONN_TBL_SIZE-1:0] open_map;
    logic error;
  } ConnSetupStatus;
endpackage

// File: rtl/rpc_multi_channel_if.sv
// rpc_multi_channel_if: network tx (valid/ready) and rx (valid only) frame bus; slave = NIC side
interface rpc_multi_channel_if;
  import rpc_multi_channel_pkg::*;
  NetworkPacketInternal network_tx_out, network_rx_in;
  logic network_tx_valid_out, network_tx_ready_in, network_rx_valid_in;
  modport master(input network_tx_out, network_tx_valid_out, output network_tx_ready_in, network_rx_in, network_rx_valid_in);
  modport slave(output network_tx_out, network_tx_valid_out, input network_tx_ready_in, network_rx_in, network_rx_valid_in);
endinterface

// File: rtl/connection_manager.sv
// connection_manager: applies enable pulses from c_ctl to the open-connection map; status/initialized out
module connection_manager import rpc_multi_channel_pkg::*; #(
  parameter int LCACHE_SIZE = LCONN_TBL_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic initialize,
  input  ConnectionControlIf c_ctl,
  output ConnSetupStatus status,
  output logic initialized
);
  localparam int IW = $clog2(LCONN_TBL_SIZE);
  logic unused_fields;
  assign unused_fields = ^{c_ctl.dest_ip, c_ctl.dest_port, c_ctl.client_flow_id};
  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
      initialized <= 1'b0;
    end else begin
      if (initialize) initialized <= 1'b1;
      if (c_ctl.enable) begin
        if (c_ctl.conn_id < 16'(LCACHE_SIZE)) status.open_map[c_ctl.conn_id[IW-1:0]] <= c_ctl.open;
        else status.error <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/rpc_multi_channel_tx_fifo.sv
// rpc_tx_fifo: per-channel RpcIf FIFO (push/pop in, dout/full/empty out) with registered occupancy count
module rpc_tx_fifo import rpc_multi_channel_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  RpcIf din,
  output RpcIf dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  RpcIf mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/rpc_multi_channel.sv
// rpc_multi_channel: N_CH RPC channels -> FIFOs -> round-robin -> network frames; rx demux by conn_id; setup parser
module rpc_multi_channel import rpc_multi_channel_pkg::*; #(
  parameter int NIC_ID = 0,
  parameter int N_CH = 4,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int MAX_ARGL = RPC_MAX_ARGL_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic initialize,
  input  logic conn_setup_en_in,
  input  ConnSetupFrame conn_setup_frame_in,
  output ConnSetupStatus conn_setup_status_out,
  input  logic [N_CH-1:0] rpc_valid_in,
  input  RpcIf [N_CH-1:0] rpc_in,
  output logic [N_CH-1:0] rpc_ready_out,
  output logic [N_CH-1:0] rpc_valid_out,
  output RpcIf [N_CH-1:0] rpc_out,
  rpc_multi_channel_if.slave net,
  output logic [15:0] drop_cnt_out,
  output logic initialized,
  output logic error
);
  localparam int CW = $clog2(N_CH);
  localparam int RW = $bits(RpcPckt);
  if (N_CH < 2 || N_CH > 16 || (N_CH & (N_CH - 1)) != 0 || NIC_ID < 0) begin : g_bad_param
    $error("rpc_multi_channel: illegal parameters");
  end
  logic [N_CH-1:0] push, pop, full, empty, drops;
  RpcIf fifo_out [N_CH];
  RpcIf sel, rx_word;
  NetworkPacketInternal frame;
  logic [CW-1:0] last_grant, gnt, rx_ch;
  logic gnt_v, pop_ok, drop_err, parse_err, en_ok, unused_rx;
  logic [16:0] drop_sum;
  logic [4:0] setup_vec;
  ConnectionControlIf c_ctl;
  assign rpc_ready_out = ~full;
  assign drops = rpc_valid_in & rpc_ready_out & ~push;
  assign pop_ok = !net.network_tx_valid_out | net.network_tx_ready_in;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign push[c] = rpc_valid_in[c] & rpc_ready_out[c] & (rpc_in[c].rpc_data.hdr.argl <= 16'(MAX_ARGL));
    assign pop[c] = pop_ok & gnt_v & (gnt == CW'(c));
    rpc_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push[c]), .pop(pop[c]), .din(rpc_in[c]),
      .dout(fifo_out[c]), .full(full[c]), .empty(empty[c])
    );
  end
  always_comb begin
    gnt = last_grant;
    gnt_v = 1'b0;
    for (int i = N_CH; i >= 1; i--)
      if (!empty[last_grant + CW'(i)]) begin
        gnt = last_grant + CW'(i);
        gnt_v = 1'b1;
      end
  end
  assign sel = fifo_out[gnt];
  always_comb begin
    frame = '0;
    frame.conn_id = sel.flow_id;
    frame.hdr.payload_size = 16'($bits(RpcHeader) >> 3) + sel.rpc_data.hdr.argl;
    frame.payload[RW-1:0] = sel.rpc_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      net.network_tx_valid_out <= 1'b0;
      net.network_tx_out <= '0;
      last_grant <= CW'(N_CH - 1);
    end else if (pop_ok) begin
      net.network_tx_valid_out <= gnt_v;
      if (gnt_v) begin
        net.network_tx_out <= frame;
        last_grant <= gnt;
      end
    end
  end
  assign drop_sum = {1'b0, drop_cnt_out} + 17'($countones(drops));
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_out <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_cnt_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      drop_err <= drop_err | (|drops);
    end
  end
  assign rx_ch = net.network_rx_in.conn_id[CW-1:0];
  assign rx_word = {net.network_rx_in.conn_id, net.network_rx_in.payload[RW-1:0]};
  assign unused_rx = ^{net.network_rx_in.hdr, net.network_rx_in.payload[NET_PAYLOAD_W-1:RW]};
  always_ff @(posedge clk) begin
    if (reset) begin
      rpc_valid_out <= '0;
      rpc_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rpc_valid_out[i] <= net.network_rx_valid_in && rx_ch == CW'(i);
        rpc_out[i] <= (net.network_rx_valid_in && rx_ch == CW'(i)) ? rx_word : '0;
      end
    end
  end
  assign en_ok = c_ctl.open ? &setup_vec : setup_vec[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      c_ctl <= '0;
      setup_vec <= '0;
      parse_err <= 1'b0;
    end else begin
      c_ctl.enable <= 1'b0;
      if (conn_setup_en_in)
        case (conn_setup_frame_in.cmd)
          setUpConnId: begin
            c_ctl.conn_id <= conn_setup_frame_in.data[15:0];
            setup_vec[0] <= 1'b1;
          end
          setUpOpen: begin
            c_ctl.open <= conn_setup_frame_in.data[0];
            setup_vec[1] <= 1'b1;
          end
          setUpDestIPv4: begin
            c_ctl.dest_ip <= conn_setup_frame_in.data;
            setup_vec[2] <= 1'b1;
          end
          setUpDestPort: begin
            c_ctl.dest_port <= conn_setup_frame_in.data[15:0];
            setup_vec[3] <= 1'b1;
          end
          setUpClientFlowId: begin
            c_ctl.client_flow_id <= conn_setup_frame_in.data[15:0];
            setup_vec[4] <= 1'b1;
          end
          setUpEnable: begin
            c_ctl.enable <= en_ok;
            parse_err <= parse_err | !en_ok;
            setup_vec <= '0;
          end
          default: begin
            parse_err <= 1'b1;
            setup_vec <= '0;
          end
        endcase
    end
  end
  connection_manager #(.LCACHE_SIZE(LCONN_TBL_SIZE)) u_cm (
    .clk(clk), .reset(reset), .initialize(initialize), .c_ctl(c_ctl),
    .status(conn_setup_status_out), .initialized(initialized)
  );
  assign error = parse_err | drop_err | conn_setup_status_out.error;
endmodule

// File: tb/tb_rpc_multi_channel.sv
// tb_rpc_multi_channel: directed self-checking bench for rpc_multi_channel
module tb_rpc_multi_channel;
  import rpc_multi_channel_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic initialize = 1'b0;
  logic conn_setup_en_in = 1'b0;
  ConnSetupFrame conn_setup_frame_in = '0;
  ConnSetupStatus st;
  logic [3:0] rpc_valid_in = '0;
  logic [3:0] rpc_ready_out, rpc_valid_out;
  RpcIf [3:0] rpc_in = '0;
  RpcIf [3:0] rpc_out;
  logic [15:0] drop_cnt;
  logic initialized, error;
  int ncmp = 0;
  int nerr = 0;
  RpcIf r1, r2;
  NetworkPacketInternal nf;
  rpc_multi_channel_if nif();
  rpc_multi_channel #(.NIC_ID(0), .N_CH(4), .TX_FIFO_DEPTH(8), .MAX_ARGL(64)) dut (
    .clk(clk), .reset(reset), .initialize(initialize), .conn_setup_en_in(conn_setup_en_in),
    .conn_setup_frame_in(conn_setup_frame_in), .conn_setup_status_out(st),
    .rpc_valid_in(rpc_valid_in), .rpc_in(rpc_in), .rpc_ready_out(rpc_ready_out),
    .rpc_valid_out(rpc_valid_out), .rpc_out(rpc_out), .net(nif),
    .drop_cnt_out(drop_cnt), .initialized(initialized), .error(error)
  );
  always #5 clk = ~clk;
  function automatic RpcIf mk(input logic [15:0] flow, input logic [15:0] argl, input logic [31:0] id);
    mk = '0;
    mk.flow_id = flow;
    mk.rpc_data.hdr.rpc_id = id;
    mk.rpc_data.hdr.fn_id = 16'hBEEF;
    mk.rpc_data.hdr.argl = argl;
    mk.rpc_data.args = {id, ~id};
  endfunction
  function automatic NetworkPacketInternal fr(input RpcIf r);
    fr = '0;
    fr.conn_id = r.flow_id;
    fr.hdr.payload_size = 16'd8 + r.rpc_data.hdr.argl;
    fr.payload[127:0] = r.rpc_data;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setup(input SetupCmd c, input logic [31:0] d);
    conn_setup_en_in = 1'b1;
    conn_setup_frame_in.cmd = c;
    conn_setup_frame_in.data = d;
    tick();
    conn_setup_en_in = 1'b0;
  endtask
  initial begin
    nif.network_tx_ready_in = 1'b0;
    nif.network_rx_valid_in = 1'b0;
    nif.network_rx_in = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_tx_valid", 256'(nif.network_tx_valid_out), 256'(1'b0));
    chk("rst_tx_out", 256'(nif.network_tx_out), 256'(0));
    chk("rst_rx_valid", 256'(rpc_valid_out), 256'(4'h0));
    chk("rst_rx_out", 256'(rpc_out), 256'(0));
    chk("rst_ready", 256'(rpc_ready_out), 256'(4'hF));
    chk("rst_drop", 256'(drop_cnt), 256'(16'd0));
    chk("rst_error", 256'(error), 256'(1'b0));
    chk("rst_init", 256'(initialized), 256'(1'b0));
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    chk("initialized", 256'(initialized), 256'(1'b1));
    // single RPC on ch2
    r1 = mk(16'd5, 16'd16, 32'hA1);
    rpc_in[2] = r1;
    rpc_valid_in = 4'b0100;
    nif.network_tx_ready_in = 1'b1;
    tick();
    rpc_valid_in = '0;
    chk("single_t1_valid", 256'(nif.network_tx_valid_out), 256'(1'b0));
    tick();
    chk("single_t2_valid", 256'(nif.network_tx_valid_out), 256'(1'b1));
    chk("single_frame", 256'(nif.network_tx_out), 256'(fr(r1)));
    chk("single_conn_id", 256'(nif.network_tx_out.conn_id), 256'(16'd5));
    chk("single_psize", 256'(nif.network_tx_out.hdr.payload_size), 256'(16'd24));
    tick();
    chk("single_one_cycle", 256'(nif.network_tx_valid_out), 256'(1'b0));
    // reset while a frame is held
    rpc_in[3] = mk(16'd7, 16'd4, 32'h77);
    rpc_valid_in = 4'b1000;
    nif.network_tx_ready_in = 1'b0;
    tick();
    rpc_valid_in = '0;
    tick();
    chk("held_before_reset", 256'(nif.network_tx_valid_out), 256'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_valid", 256'(nif.network_tx_valid_out), 256'(1'b0));
    chk("midreset_out", 256'(nif.network_tx_out), 256'(0));
    tick();
    chk("midreset_fifo_flushed", 256'(nif.network_tx_valid_out), 256'(1'b0));
    // round robin: 3 RPCs per channel, output held until all queued
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) rpc_in[c] = mk(16'(c), 16'd4, 32'(16 * c + k));
      rpc_valid_in = 4'hF;
      tick();
    end
    rpc_valid_in = '0;
    nif.network_tx_ready_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rr_%0d", i), 256'(nif.network_tx_out), 256'(fr(mk(16'(i % 4), 16'd4, 32'(16 * (i % 4) + i / 4)))));
      chk($sformatf("rr_valid_%0d", i), 256'(nif.network_tx_valid_out), 256'(1'b1));
      tick();
    end
    chk("rr_drained", 256'(nif.network_tx_valid_out), 256'(1'b0));
    // backpressure on ch0
    nif.network_tx_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_ready_%0d", i), 256'(rpc_ready_out[0]), 256'(i < 9));
      chk($sformatf("bp_valid_%0d", i), 256'(nif.network_tx_valid_out), 256'(i >= 2));
      if (i >= 2) chk($sformatf("bp_hold_%0d", i), 256'(nif.network_tx_out), 256'(fr(mk(16'd0, 16'd2, 32'h100))));
      rpc_in[0] = mk(16'd0, 16'd2, 32'(256 + i));
      rpc_valid_in = 4'b0001;
      tick();
    end
    rpc_valid_in = '0;
    nif.network_tx_ready_in = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("bp_out_%0d", j), 256'(nif.network_tx_out), 256'(fr(mk(16'd0, 16'd2, 32'(256 + j)))));
      chk($sformatf("bp_out_valid_%0d", j), 256'(nif.network_tx_valid_out), 256'(1'b1));
      tick();
    end
    chk("bp_drained", 256'(nif.network_tx_valid_out), 256'(1'b0));
    chk("bp_ready_back", 256'(rpc_ready_out), 256'(4'hF));
    // argl at the bound then one over it on ch1
    r1 = mk(16'd1, 16'd64, 32'h2FF);
    rpc_in[1] = r1;
    rpc_valid_in = 4'b0010;
    tick();
    rpc_in[1] = mk(16'd1, 16'd65, 32'h300);
    chk("max_argl_no_drop", 256'(drop_cnt), 256'(16'd0));
    tick();
    rpc_valid_in = '0;
    chk("max_argl_frame", 256'(nif.network_tx_out), 256'(fr(r1)));
    chk("max_argl_psize", 256'(nif.network_tx_out.hdr.payload_size), 256'(16'd72));
    chk("oversize_drop", 256'(drop_cnt), 256'(16'd1));
    chk("oversize_error", 256'(error), 256'(1'b1));
    tick();
    chk("oversize_no_frame", 256'(nif.network_tx_valid_out), 256'(1'b0));
    repeat (3) tick();
    chk("oversize_error_sticky", 256'(error), 256'(1'b1));
    chk("oversize_drop_stays", 256'(drop_cnt), 256'(16'd1));
    // rx demux, back-to-back
    r1 = mk(16'd6, 16'd16, 32'h55);
    r2 = mk(16'd9, 16'd8, 32'h66);
    nf = '0;
    nf.conn_id = 16'd6;
    nf.hdr.payload_size = 16'd24;
    nf.payload = {64'hFFFF_FFFF_FFFF_FFFF, r1.rpc_data};
    nif.network_rx_in = nf;
    nif.network_rx_valid_in = 1'b1;
    tick();
    chk("rx1_valid", 256'(rpc_valid_out), 256'(4'b0100));
    chk("rx1_data", 256'(rpc_out[2]), 256'(r1));
    chk("rx1_other_zero", 256'(rpc_out[0]), 256'(0));
    nf.conn_id = 16'd9;
    nf.payload = {64'h0123_4567_89AB_CDEF, r2.rpc_data};
    nif.network_rx_in = nf;
    tick();
    nif.network_rx_valid_in = 1'b0;
    chk("rx2_valid", 256'(rpc_valid_out), 256'(4'b0010));
    chk("rx2_data", 256'(rpc_out[1]), 256'(r2));
    chk("rx2_prev_cleared", 256'(rpc_out[2]), 256'(0));
    tick();
    chk("rx_idle", 256'(rpc_valid_out), 256'(4'b0000));
    // setup: incomplete open, reset, full open, close, unknown command
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("setup_rst_error", 256'(error), 256'(1'b0));
    chk("setup_rst_drop", 256'(drop_cnt), 256'(16'd0));
    setup(setUpConnId, 32'd3);
    setup(setUpOpen, 32'd1);
    setup(setUpDestIPv4, 32'hC0A8_0001);
    setup(setUpClientFlowId, 32'h11);
    setup(setUpEnable, 32'd0);
    chk("setup_bad_no_enable", 256'(dut.c_ctl.enable), 256'(1'b0));
    chk("setup_bad_error", 256'(error), 256'(1'b1));
    chk("setup_bad_vec", 256'(dut.setup_vec), 256'(5'd0));
    tick();
    chk("setup_bad_map", 256'(st.open_map), 256'(16'h0000));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("setup_rst2_error", 256'(error), 256'(1'b0));
    setup(setUpConnId, 32'd3);
    setup(setUpOpen, 32'd1);
    setup(setUpDestIPv4, 32'hC0A8_0001);
    setup(setUpDestPort, 32'd80);
    chk("setup_vec_full", 256'(dut.setup_vec), 256'(5'b01111));
    setup(setUpClientFlowId, 32'h11);
    setup(setUpEnable, 32'd0);
    chk("setup_ok_enable", 256'(dut.c_ctl.enable), 256'(1'b1));
    chk("setup_ok_vec", 256'(dut.setup_vec), 256'(5'd0));
    chk("setup_ok_error", 256'(error), 256'(1'b0));
    tick();
    chk("setup_ok_single_pulse", 256'(dut.c_ctl.enable), 256'(1'b0));
    chk("setup_ok_map", 256'(st.open_map), 256'(16'h0008));
    chk("setup_ok_error2", 256'(error), 256'(1'b0));
    setup(setUpConnId, 32'd3);
    setup(setUpOpen, 32'd0);
    setup(setUpEnable, 32'd0);
    chk("close_enable", 256'(dut.c_ctl.enable), 256'(1'b1));
    tick();
    chk("close_map", 256'(st.open_map), 256'(16'h0000));
    chk("close_error", 256'(error), 256'(1'b0));
    setup(SetupCmd'(3'd7), 32'd0);
    chk("unknown_cmd_error", 256'(error), 256'(1'b1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
